// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the iterative integer square-root engine.
package isqrt_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   // Number of CALC cycles for a w-bit radicand resolving s root bits per clock.
   function automatic int iters(input int w, input int s);
      return w / (2 * s);
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
module isqrt_step
   import isqrt_pkg::*;
#(
   parameter int ROOT_W = 16
) (
   input  logic [ROOT_W:0]   rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [1:0]        bits,
   output logic [ROOT_W:0]   rem_nxt,
   output logic [ROOT_W-1:0] root_nxt
);

   logic [ROOT_W+2:0] r_sh;
   logic [ROOT_W+2:0] t;
   logic              ge;

   // One guard bit above the minimum keeps every operand bit live.
   assign r_sh = {rem, bits};
   assign t    = {1'b0, root, 2'b01};
   assign ge   = (r_sh >= t);

   // The true remainder never exceeds 2*root, so REM_W bits always hold it.
   assign rem_nxt  = ge ? (ROOT_W+1)'(r_sh - t) : (ROOT_W+1)'(r_sh);
   assign root_nxt = {root[ROOT_W-2:0], ge};

endmodule

// File: rtl/isqrt_datapath.sv
// Iterative unsigned integer square root with start/ready/done handshake and abort.
module isqrt_datapath
   import isqrt_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   output logic                    ready_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [DATA_WIDTH/2-1:0] root_o,
   output logic [DATA_WIDTH/2:0]   rem_o,
   output logic                    zero_o,
   output logic                    exact_o
);

   localparam int ROOT_W = DATA_WIDTH / 2;
   localparam int REM_W  = ROOT_W + 1;
   localparam int ITERS  = iters(DATA_WIDTH, STEPS_PER_CYCLE);
   localparam int CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] rad;
   logic [REM_W-1:0]      rem;
   logic [ROOT_W-1:0]     root;
   logic [CNT_W-1:0]      cnt;

   logic [STEPS_PER_CYCLE:0][REM_W-1:0]  rem_c;
   logic [STEPS_PER_CYCLE:0][ROOT_W-1:0] root_c;

   logic accept, last;

   assign accept = (state == IDLE) && start_i && !abort_i;
   assign last   = (cnt == '0);

   assign rem_c[0]  = rem;
   assign root_c[0] = root;

   // Chain of steps; step g consumes the g-th radicand bit pair from the top.
   for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
      isqrt_step #(.ROOT_W(ROOT_W)) u_step (
         .rem      (rem_c[g]),
         .root     (root_c[g]),
         .bits     (rad[DATA_WIDTH-1-2*g -: 2]),
         .rem_nxt  (rem_c[g+1]),
         .root_nxt (root_c[g+1])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (abort_i) state_nxt = IDLE;
                  else if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state)
         IDLE:    ready_o = 1'b1;
         CALC:    busy_o  = 1'b1;
         DONE:    done_o  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rad     <= '0;
         rem     <= '0;
         root    <= '0;
         cnt     <= '0;
         root_o  <= '0;
         rem_o   <= '0;
         zero_o  <= 1'b1;
         exact_o <= 1'b1;
      end else if (accept) begin
         rad  <= data_i;
         rem  <= '0;
         root <= '0;
         cnt  <= CNT_W'(ITERS - 1);
      end else if (state == CALC && !abort_i) begin
         rad  <= rad << (2 * STEPS_PER_CYCLE);
         rem  <= rem_c[STEPS_PER_CYCLE];
         root <= root_c[STEPS_PER_CYCLE];
         if (!last) begin
            cnt <= cnt - 1'b1;
         end else begin
            // Results are captured only on the edge entering DONE.
            root_o  <= root_c[STEPS_PER_CYCLE];
            rem_o   <= rem_c[STEPS_PER_CYCLE];
            zero_o  <= (root_c[STEPS_PER_CYCLE] == '0);
            exact_o <= (rem_c[STEPS_PER_CYCLE] == '0);
         end
      end
   end

endmodule

// File: tb/tb_isqrt_datapath.sv
// Scoreboard bench for isqrt_datapath: 32/1 and 32/2 instances, directed plus model-checked values.
module tb_isqrt_datapath;

   localparam int RW = 16;
   localparam int MW = 17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          start_a = 1'b0, abort_a = 1'b0;
   logic [31:0]   data_a = '0;
   logic          ready_a, busy_a, done_a, zero_a, exact_a;
   logic [RW-1:0] root_a;
   logic [MW-1:0] rem_a;

   logic          start_b = 1'b0, abort_b = 1'b0;
   logic [31:0]   data_b = '0;
   logic          ready_b, busy_b, done_b, zero_b, exact_b;
   logic [RW-1:0] root_b;
   logic [MW-1:0] rem_b;

   isqrt_datapath #(.DATA_WIDTH(32), .STEPS_PER_CYCLE(1)) dut_a (
      .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a), .data_i(data_a),
      .ready_o(ready_a), .busy_o(busy_a), .done_o(done_a),
      .root_o(root_a), .rem_o(rem_a), .zero_o(zero_a), .exact_o(exact_a));

   isqrt_datapath #(.DATA_WIDTH(32), .STEPS_PER_CYCLE(2)) dut_b (
      .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b), .data_i(data_b),
      .ready_o(ready_b), .busy_o(busy_b), .done_o(done_b),
      .root_o(root_b), .rem_o(rem_b), .zero_o(zero_b), .exact_o(exact_b));

   typedef struct {
      logic [RW-1:0] root;
      logic [MW-1:0] rem;
      logic          zero;
      logic          exact;
      int            due;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic cmp(input string name, input longint act, input longint req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_out(input string p, input exp_t e, input logic [RW-1:0] r,
                            input logic [MW-1:0] m, input logic z, input logic x);
      cmp({p, "_root"}, r, e.root);
      cmp({p, "_rem"}, m, e.rem);
      cmp({p, "_zero"}, z, e.zero);
      cmp({p, "_exact"}, x, e.exact);
      cmp({p, "_latency"}, cyc, e.due);
   endtask

   // Independent reference: greedy bit search on the square itself.
   function automatic exp_t model(input logic [31:0] x);
      exp_t   e;
      longint r = 0;
      for (int b = RW - 1; b >= 0; b--) begin
         longint c = r | (longint'(1) << b);
         if (c * c <= longint'(x)) r = c;
      end
      e.root  = RW'(r);
      e.rem   = MW'(longint'(x) - r * r);
      e.zero  = (r == 0);
      e.exact = (longint'(x) == r * r);
      e.due   = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done_a) begin
         if (q_a.size() == 0) cmp("a_unexpected_done", 1, 0);
         else begin
            e = q_a.pop_front();
            check_out("a", e, root_a, rem_a, zero_a, exact_a);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done_b) begin
         if (q_b.size() == 0) cmp("b_unexpected_done", 1, 0);
         else begin
            e = q_b.pop_front();
            check_out("b", e, root_b, rem_b, zero_b, exact_b);
         end
      end
   end

   // Waits for ready, presents one request, and optionally scoreboards the answer.
   task automatic issue(input bit sel, input logic [31:0] x, input bit push,
                        input logic [RW-1:0] er, input logic [MW-1:0] em);
      exp_t e;
      int   guard = 0;
      int   it    = sel ? 8 : 16;
      @(negedge clk);
      while (!(sel ? ready_b : ready_a) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         cmp("ready_timeout", 0, 1);
         return;
      end
      if (sel) begin start_b = 1'b1; data_b = x; end
      else     begin start_a = 1'b1; data_a = x; end
      @(posedge clk);
      #1;
      if (push) begin
         e.root  = er;
         e.rem   = em;
         e.zero  = (er == 0);
         e.exact = (em == 0);
         e.due   = cyc + it;
         if (sel) q_b.push_back(e);
         else     q_a.push_back(e);
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 60) cmp("drain_timeout", 0, 1);
   endtask

   task automatic check_reset_a();
      cmp("rst_ready", ready_a, 1);
      cmp("rst_busy", busy_a, 0);
      cmp("rst_done", done_a, 0);
      cmp("rst_root", root_a, 0);
      cmp("rst_rem", rem_a, 0);
      cmp("rst_zero", zero_a, 1);
      cmp("rst_exact", exact_a, 1);
   endtask

   initial begin
      exp_t        m;
      logic [31:0] x;

      #12;
      @(negedge clk);
      check_reset_a();
      cmp("rst_b_ready", ready_b, 1);
      cmp("rst_b_zero", zero_b, 1);
      rst = 1'b0;

      // Directed 32/1 vectors
      issue(0, 32'd0, 1, 16'd0, 17'd0);
      issue(0, 32'd16, 1, 16'd4, 17'd0);
      issue(0, 32'd17, 1, 16'd4, 17'd1);
      issue(0, 32'hFFFF_FFFF, 1, 16'd65535, 17'd131070);
      drain();

      // A second start during CALC must be dropped
      issue(0, 32'd144, 1, 16'd12, 17'd0);
      repeat (3) @(negedge clk);
      cmp("busy_in_calc", busy_a, 1);
      start_a = 1'b1;
      data_a  = 32'd1000000;
      @(negedge clk);
      start_a = 1'b0;
      drain();
      repeat (20) @(negedge clk);

      // Abort in CALC cycle 5
      issue(0, 32'd1000000, 0, '0, '0);
      repeat (4) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      cmp("abort_ready", ready_a, 1);
      cmp("abort_busy", busy_a, 0);
      cmp("abort_root_kept", root_a, 12);
      cmp("abort_exact_kept", exact_a, 1);
      repeat (20) @(negedge clk);

      // Abort beats start in IDLE
      start_a = 1'b1;
      abort_a = 1'b1;
      data_a  = 32'd99;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      cmp("idle_abort_busy", busy_a, 0);
      cmp("idle_abort_ready", ready_a, 1);

      // Reset mid-CALC
      issue(0, 32'd1000000, 0, '0, '0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_a();
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 60; i++) begin
         x = (i % 3 == 0) ? 32'($urandom_range(0, 5000)) : 32'($urandom);
         m = model(x);
         issue(0, x, 1, m.root, m.rem);
      end
      drain();

      // 32/2 instance
      issue(1, 32'd1000000, 1, 16'd1000, 17'd0);
      issue(1, 32'd0, 1, 16'd0, 17'd0);
      issue(1, 32'hFFFF_FFFF, 1, 16'd65535, 17'd131070);
      issue(1, 32'd15, 1, 16'd3, 17'd6);
      for (int i = 0; i < 60; i++) begin
         x = (i % 3 == 0) ? 32'($urandom_range(0, 5000)) : 32'($urandom);
         m = model(x);
         issue(1, x, 1, m.root, m.rem);
      end
      drain();
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
